// File: rtl/lut_array_pkg.sv
// lut_array_pkg: FSM state type and config-size helpers shared by the LUT array.
package lut_array_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  function automatic int seg_bits(int k);
    return (1 << k) + 1;
  endfunction
  function automatic int cfg_bits(int k, int n);
    return n * seg_bits(k);
  endfunction
endpackage

// File: rtl/lut_array_if.sv
// lut_array_if: serial configuration handshake between a loader and the LUT array.
interface lut_array_if;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic cfg_commit;
  logic cfg_done;
  logic cfg_err;
  logic cfg_dout;
  modport master (output cfg_valid, cfg_data, cfg_commit, input cfg_ready, cfg_done, cfg_err, cfg_dout);
  modport slave (input cfg_valid, cfg_data, cfg_commit, output cfg_ready, cfg_done, cfg_err, cfg_dout);
endinterface

// File: rtl/lut_array_cell.sv
// lut_cell: one K-input LUT with selectable combinational or registered output.
module lut_cell #(
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K-1:0]     sel,
  input  logic [(1<<K):0]  cfg,
  output logic             out
);
  localparam int T = 1 << K;
  logic [T-1:0] tt;
  logic v, r;
  assign tt = cfg[T-1:0];
  assign v = tt[sel];
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= 1'b0;
    else r <= v;
  assign out = cfg[T] ? r : v;
endmodule

// File: rtl/lut_array.sv
// lut_array: N K-input LUTs configured through a serial shadow chain with atomic commit.
module lut_array
  import lut_array_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*K-1:0] lut_in,
  output logic [N-1:0]   lut_out,
  lut_array_if.slave     bus
);
  localparam int SEG = seg_bits(K);
  localparam int CB = cfg_bits(K, N);
  localparam int CW = $clog2(CB + 1);
  state_t state;
  logic [CB-1:0] shadow, active;
  logic [CW-1:0] cnt;
  logic take;
  assign bus.cfg_ready = (state != COMMIT) && !bus.cfg_commit;
  assign take = bus.cfg_valid && bus.cfg_ready;
  assign bus.cfg_dout = shadow[0];
  // Commit and accept are mutually exclusive because cfg_commit masks cfg_ready.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      active <= '0;
      cnt <= '0;
      bus.cfg_done <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.cfg_done <= 1'b0;
      if (take) begin
        shadow <= {bus.cfg_data, shadow[CB-1:1]};
        cnt <= (cnt == CW'(CB)) ? cnt : cnt + 1'b1;
        bus.cfg_err <= 1'b0;
      end
      case (state)
        IDLE:
          if (take) state <= LOAD;
          else if (bus.cfg_commit) bus.cfg_err <= 1'b1;
        LOAD:
          if (bus.cfg_commit) begin
            if (cnt == CW'(CB)) state <= COMMIT;
            else begin
              bus.cfg_err <= 1'b1;
              cnt <= '0;
              state <= IDLE;
            end
          end
        COMMIT: begin
          active <= shadow;
          bus.cfg_done <= 1'b1;
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < N; i++) begin : g_lut
    lut_cell #(.K(K)) u_cell (
      .clk(clk),
      .rst(rst),
      .sel(lut_in[i*K +: K]),
      .cfg(active[i*SEG +: SEG]),
      .out(lut_out[i])
    );
  end
endmodule

// File: tb/tb_lut_array.sv
// tb_lut_array: directed checks of the LUT array against a queue-based behavioural model.
module tb_lut_array;
  localparam int K = 4;
  localparam int N = 8;
  localparam int T = 1 << K;
  localparam int SEG = T + 1;
  localparam int CB = N * SEG;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*K-1:0] lut_in = '0;
  logic [N-1:0] lut_out;
  lut_array_if bus();
  lut_array #(.K(K), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .lut_in(lut_in),
    .lut_out(lut_out),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;
  // Model: hist holds the last CB accepted bits, oldest at index 0.
  bit hist[$];
  logic [T-1:0] tbl [N];
  bit md [N];
  bit rg [N];
  bit busy, m_err, m_done, take;
  int cnt;
  logic [N+3:0] act_v, exp_v;
  logic [CB-1:0] c, c2, c3;
  logic [N-1:0] saved;
  task automatic m_reset();
    hist.delete();
    repeat (CB) hist.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      tbl[i] = '0;
      md[i] = 1'b0;
      rg[i] = 1'b0;
    end
    busy = 1'b0;
    m_err = 1'b0;
    m_done = 1'b0;
    cnt = 0;
  endtask
  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) o[i] = md[i] ? rg[i] : tbl[i][lut_in[i*K +: K]];
    return o;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) m_reset();
    else begin
      take = bus.cfg_valid && !busy && !bus.cfg_commit;
      for (int i = 0; i < N; i++) rg[i] = tbl[i][lut_in[i*K +: K]];
      m_done = busy;
      if (busy) begin
        for (int i = 0; i < N; i++) begin
          for (int b = 0; b < T; b++) tbl[i][b] = hist[i*SEG+b];
          md[i] = hist[i*SEG+T];
        end
        busy = 1'b0;
        cnt = 0;
      end else if (take) begin
        void'(hist.pop_front());
        hist.push_back(bus.cfg_data);
        cnt = (cnt < CB) ? cnt + 1 : cnt;
        m_err = 1'b0;
      end else if (bus.cfg_commit) begin
        if (cnt == CB) busy = 1'b1;
        else begin
          m_err = 1'b1;
          cnt = 0;
        end
      end
    end
  always @(negedge clk)
    if (!rst) begin
      act_v = {lut_out, bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.cfg_dout};
      exp_v = {exp_out(), !busy && !bus.cfg_commit, m_done, m_err, hist[0]};
      vecs++;
      if (act_v !== exp_v) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t {out,ready,done,err,dout} got=%h want=%h", $time, act_v, exp_v);
      end
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input bit b);
    bus.cfg_valid = 1'b1;
    bus.cfg_data = b;
    step();
    bus.cfg_valid = 1'b0;
  endtask
  task automatic send_cfg(input logic [CB-1:0] v);
    for (int j = 0; j < CB; j++) send_bit(v[j]);
  endtask
  task automatic do_commit();
    bus.cfg_commit = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
  endtask
  initial begin
    m_reset();
    bus.cfg_valid = 1'b0;
    bus.cfg_data = 1'b0;
    bus.cfg_commit = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_lut_out", 32'(lut_out), 32'h0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'h1);
    chk("rst_err", 32'(bus.cfg_err), 32'h0);
    chk("rst_done", 32'(bus.cfg_done), 32'h0);
    rst = 1'b0;
    step();
    c = '0;
    c[15:0] = 16'h8000;
    send_cfg(c);
    do_commit();
    chk("done_early", 32'(bus.cfg_done), 32'h0);
    step();
    chk("done_pulse", 32'(bus.cfg_done), 32'h1);
    lut_in[3:0] = 4'hF;
    #1 chk("lut0_F", 32'(lut_out[0]), 32'h1);
    lut_in[3:0] = 4'hE;
    #1 chk("lut0_E", 32'(lut_out[0]), 32'h0);
    step();
    chk("done_clear", 32'(bus.cfg_done), 32'h0);
    c2 = c;
    c2[SEG +: SEG] = {1'b1, 16'h6996};
    lut_in = '0;
    send_cfg(c2);
    do_commit();
    step();
    chk("lut1_init", 32'(lut_out[1]), 32'h0);
    lut_in[7:4] = 4'h1;
    #1 chk("lut1_hold", 32'(lut_out[1]), 32'h0);
    step();
    chk("lut1_rise", 32'(lut_out[1]), 32'h1);
    saved = lut_out;
    chk("saved_out", 32'(saved), 32'h02);
    for (int j = 0; j < 100; j++) send_bit(1'($urandom_range(0, 1)));
    do_commit();
    chk("short_err", 32'(bus.cfg_err), 32'h1);
    chk("short_hold", 32'(lut_out), 32'(saved));
    step();
    chk("short_nodone", 32'(bus.cfg_done), 32'h0);
    send_bit(1'b1);
    chk("err_clear", 32'(bus.cfg_err), 32'h0);
    c3 = '0;
    c3[15:0] = 16'h0001;
    c3[3*SEG +: 16] = 16'h0001;
    lut_in = '0;
    repeat (10) send_bit(1'b0);
    send_cfg(c3);
    chk("dout_146", 32'(bus.cfg_dout), 32'h1);
    do_commit();
    step();
    chk("window_out", 32'(lut_out), 32'h09);
    repeat (50) send_bit(1'b1);
    rst = 1'b1;
    #1 chk("midrst_out", 32'(lut_out), 32'h0);
    chk("midrst_dout", 32'(bus.cfg_dout), 32'h0);
    step();
    rst = 1'b0;
    do_commit();
    chk("idle_commit_err", 32'(bus.cfg_err), 32'h1);
    step();
    chk("idle_nodone", 32'(bus.cfg_done), 32'h0);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
